// File: rtl/alu_seq.sv
// Registered sequential ALU: add/sub with carry-in, AND/OR, and one-bit-per-clock shifts.
// A start/busy/done handshake wraps each operation; flags C/Z/N/V load on completion.
module alu_seq #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned SHAMT_W = 3
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic [2:0]         op_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  input  logic [SHAMT_W-1:0] shamt_i,
  input  logic               flags_we_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [WIDTH-1:0]   result_o,
  output logic               carry_flag_o,
  output logic               zero_flag_o,
  output logic               neg_flag_o,
  output logic               ovf_flag_o
);

  localparam logic [2:0] OpAdd = 3'b000;
  localparam logic [2:0] OpSub = 3'b001;
  localparam logic [2:0] OpAdc = 3'b010;
  localparam logic [2:0] OpSbc = 3'b011;
  localparam logic [2:0] OpAnd = 3'b100;
  localparam logic [2:0] OpOr  = 3'b101;
  localparam logic [2:0] OpShl = 3'b110;
  localparam logic [2:0] OpShr = 3'b111;

  typedef enum logic [0:0] {StIdle, StExec} state_e;

  state_e             state_q, state_d;
  logic [2:0]         op_q, op_d;
  logic [WIDTH-1:0]   opa_q, opa_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [SHAMT_W-1:0] shamt_q, shamt_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic               fwe_q, fwe_d;
  logic               cin_q, cin_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               c_q, c_d, z_q, z_d, n_q, n_d, v_q, v_d;
  logic               done_q, done_d;

  logic               is_sub, is_shift, last_step, cin_eff;
  logic [WIDTH-1:0]   b_eff, res_calc;
  logic [WIDTH:0]     sum;
  logic               c_calc, v_calc;
  logic [SHAMT_W-1:0] shamt_m1;

  always_comb begin
    is_sub   = (op_q == OpSub) || (op_q == OpSbc);
    is_shift = (op_q == OpShl) || (op_q == OpShr);
    b_eff    = is_sub ? ~opb_q : opb_q;
    unique case (op_q)
      OpAdd:   cin_eff = 1'b0;
      OpSub:   cin_eff = 1'b1;
      default: cin_eff = cin_q;
    endcase
    sum       = {1'b0, opa_q} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin_eff};
    shamt_m1  = shamt_q - SHAMT_W'(1);
    // Shifts walk opa_q one bit per edge; the final edge is when cnt reaches shamt-1.
    last_step = !is_shift || (shamt_q == '0) || (cnt_q == shamt_m1);

    res_calc = sum[WIDTH-1:0];
    c_calc   = 1'b0;
    v_calc   = 1'b0;
    unique case (op_q)
      OpAdd, OpSub, OpAdc, OpSbc: begin
        res_calc = sum[WIDTH-1:0];
        c_calc   = sum[WIDTH];
        v_calc   = (opa_q[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != opa_q[WIDTH-1]);
      end
      OpAnd: res_calc = opa_q & opb_q;
      OpOr:  res_calc = opa_q | opb_q;
      OpShl: begin
        res_calc = (shamt_q == '0) ? opa_q : {opa_q[WIDTH-2:0], 1'b0};
        c_calc   = (shamt_q != '0) && opa_q[WIDTH-1];
      end
      OpShr: begin
        res_calc = (shamt_q == '0) ? opa_q : {1'b0, opa_q[WIDTH-1:1]};
        c_calc   = (shamt_q != '0) && opa_q[0];
      end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    shamt_d  = shamt_q;
    cnt_d    = cnt_q;
    fwe_d    = fwe_q;
    cin_d    = cin_q;
    result_d = result_q;
    c_d      = c_q;
    z_d      = z_q;
    n_d      = n_q;
    v_d      = v_q;
    done_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          op_d    = op_i;
          opa_d   = a_i;
          opb_d   = b_i;
          shamt_d = shamt_i;
          fwe_d   = flags_we_i;
          cin_d   = c_q;
          cnt_d   = '0;
          state_d = StExec;
        end
      end
      StExec: begin
        if (is_shift && (shamt_q != '0)) begin
          opa_d = res_calc;
          cnt_d = cnt_q + SHAMT_W'(1);
        end
        if (last_step) begin
          state_d  = StIdle;
          done_d   = 1'b1;
          result_d = res_calc;
          if (fwe_q) begin
            c_d = c_calc;
            z_d = ~|res_calc;
            n_d = res_calc[WIDTH-1];
            v_d = v_calc;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      op_q     <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      shamt_q  <= '0;
      cnt_q    <= '0;
      fwe_q    <= 1'b0;
      cin_q    <= 1'b0;
      result_q <= '0;
      c_q      <= 1'b0;
      z_q      <= 1'b0;
      n_q      <= 1'b0;
      v_q      <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      shamt_q  <= shamt_d;
      cnt_q    <= cnt_d;
      fwe_q    <= fwe_d;
      cin_q    <= cin_d;
      result_q <= result_d;
      c_q      <= c_d;
      z_q      <= z_d;
      n_q      <= n_d;
      v_q      <= v_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    busy_o       = (state_q == StExec);
    done_o       = done_q;
    result_o     = result_q;
    carry_flag_o = c_q;
    zero_flag_o  = z_q;
    neg_flag_o   = n_q;
    ovf_flag_o   = v_q;
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq: reset, arithmetic, carry chaining, shifts,
// back-to-back starts and start-while-busy.
module tb_alu_seq;

  logic       clk, rst_n, start, flags_we;
  logic [2:0] op, shamt;
  logic [7:0] a, b;
  logic       busy, done, cf, zf, nf, vf;
  logic [7:0] result;

  int n_pass = 0;
  int n_total = 0;

  alu_seq #(.WIDTH(8), .SHAMT_W(3)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .start_i      (start),
    .op_i         (op),
    .a_i          (a),
    .b_i          (b),
    .shamt_i      (shamt),
    .flags_we_i   (flags_we),
    .busy_o       (busy),
    .done_o       (done),
    .result_o     (result),
    .carry_flag_o (cf),
    .zero_flag_o  (zf),
    .neg_flag_o   (nf),
    .ovf_flag_o   (vf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200us");
    $fatal(1);
  end

  // Drives one operation; lat = edges from T0 to done (-1 on timeout), bcnt = busy samples.
  task automatic do_op(input logic [2:0] o, input logic [7:0] ia, input logic [7:0] ib,
                       input logic [2:0] sh, input logic fwe, output int lat, output int bcnt);
    @(negedge clk);
    start = 1'b1; op = o; a = ia; b = ib; shamt = sh; flags_we = fwe;
    @(posedge clk); #1;
    start = 1'b0;
    lat  = -1;
    bcnt = busy ? 1 : 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (done) begin
        if (busy) bcnt++;
        lat = i;
        break;
      end
      if (busy) bcnt++;
    end
  endtask

  task automatic test_reset();
    int lat, bcnt, ndone;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_total++;
    if ({busy, done, result, cf, zf, nf, vf} !== 14'd0)
      $display("FAIL reset_state got busy=%b done=%b res=%h flags=%b%b%b%b required all 0",
               busy, done, result, cf, zf, nf, vf);
    else n_pass++;
    rst_n = 1'b1;
    // Leave nonzero result and N flag behind so the mid-op reset has something to clear.
    do_op(3'b101, 8'hF0, 8'h0F, 3'd0, 1'b1, lat, bcnt);
    n_total++;
    if ({result, nf} !== {8'hFF, 1'b1})
      $display("FAIL pre_reset_or got res=%h N=%b required FF 1", result, nf);
    else n_pass++;
    @(negedge clk);
    start = 1'b1; op = 3'b110; a = 8'h81; shamt = 3'd5; flags_we = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    n_total++;
    if (busy !== 1'b1) $display("FAIL mid_shl_busy got %b required 1", busy);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if ({busy, done, result, cf, zf, nf, vf} !== 14'd0)
      $display("FAIL async_reset got busy=%b done=%b res=%h flags=%b%b%b%b required all 0",
               busy, done, result, cf, zf, nf, vf);
    else n_pass++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    n_total++;
    if (ndone != 0 || result !== 8'h00)
      $display("FAIL reset_abort got dones=%0d res=%h required 0 00", ndone, result);
    else n_pass++;
  endtask

  task automatic test_add_sub();
    int lat, bcnt;
    do_op(3'b000, 8'hFF, 8'h01, 3'd0, 1'b1, lat, bcnt);
    n_total++;
    if (lat != 1) $display("FAIL add_latency got %0d required 1", lat);
    else n_pass++;
    n_total++;
    if ({result, cf, zf, nf, vf} !== {8'h00, 4'b1100})
      $display("FAIL add_ff_01 got res=%h CZNV=%b%b%b%b required 00 1100", result, cf, zf, nf, vf);
    else n_pass++;
    do_op(3'b001, 8'h80, 8'h01, 3'd0, 1'b1, lat, bcnt);
    n_total++;
    if ({result, cf, zf, nf, vf} !== {8'h7F, 4'b1001})
      $display("FAIL sub_80_01 got res=%h CZNV=%b%b%b%b required 7F 1001", result, cf, zf, nf, vf);
    else n_pass++;
    do_op(3'b001, 8'h00, 8'h01, 3'd0, 1'b1, lat, bcnt);
    n_total++;
    if ({result, cf, zf, nf, vf} !== {8'hFF, 4'b0010})
      $display("FAIL sub_00_01 got res=%h CZNV=%b%b%b%b required FF 0010", result, cf, zf, nf, vf);
    else n_pass++;
  endtask

  task automatic test_carry_chain();
    int lat, bcnt;
    do_op(3'b000, 8'hFF, 8'h01, 3'd0, 1'b1, lat, bcnt);
    do_op(3'b010, 8'h00, 8'h00, 3'd0, 1'b0, lat, bcnt);
    n_total++;
    if (result !== 8'h01) $display("FAIL adc_cin got res=%h required 01", result);
    else n_pass++;
    n_total++;
    if ({cf, zf, nf, vf} !== 4'b1100)
      $display("FAIL adc_no_we_hold got CZNV=%b%b%b%b required 1100", cf, zf, nf, vf);
    else n_pass++;
    do_op(3'b010, 8'h7F, 8'h00, 3'd0, 1'b1, lat, bcnt);
    n_total++;
    if ({result, cf, zf, nf, vf} !== {8'h80, 4'b0011})
      $display("FAIL adc_7f got res=%h CZNV=%b%b%b%b required 80 0011", result, cf, zf, nf, vf);
    else n_pass++;
    do_op(3'b011, 8'h05, 8'h03, 3'd0, 1'b1, lat, bcnt);
    n_total++;
    if ({result, cf, zf, nf, vf} !== {8'h01, 4'b1000})
      $display("FAIL sbc_05_03 got res=%h CZNV=%b%b%b%b required 01 1000", result, cf, zf, nf, vf);
    else n_pass++;
    do_op(3'b100, 8'hF0, 8'h3C, 3'd0, 1'b1, lat, bcnt);
    n_total++;
    if ({result, cf, zf, nf, vf} !== {8'h30, 4'b0000})
      $display("FAIL and_f0_3c got res=%h CZNV=%b%b%b%b required 30 0000", result, cf, zf, nf, vf);
    else n_pass++;
  endtask

  task automatic test_shift();
    int lat, bcnt;
    do_op(3'b110, 8'hB1, 8'h00, 3'd3, 1'b1, lat, bcnt);
    n_total++;
    if (lat != 3 || bcnt != 3)
      $display("FAIL shl3_timing got lat=%0d busy=%0d required 3 3", lat, bcnt);
    else n_pass++;
    n_total++;
    if ({result, cf, zf, nf, vf} !== {8'h88, 4'b1010})
      $display("FAIL shl3_b1 got res=%h CZNV=%b%b%b%b required 88 1010", result, cf, zf, nf, vf);
    else n_pass++;
    do_op(3'b111, 8'h01, 8'h00, 3'd1, 1'b1, lat, bcnt);
    n_total++;
    if ({lat[7:0], result, cf, zf, nf, vf} !== {8'd1, 8'h00, 4'b1100})
      $display("FAIL shr1_01 got lat=%0d res=%h CZNV=%b%b%b%b required 1 00 1100",
               lat, result, cf, zf, nf, vf);
    else n_pass++;
    do_op(3'b110, 8'h5A, 8'h00, 3'd0, 1'b1, lat, bcnt);
    n_total++;
    if ({lat[7:0], result, cf, zf, nf, vf} !== {8'd1, 8'h5A, 4'b0000})
      $display("FAIL shl0_5a got lat=%0d res=%h CZNV=%b%b%b%b required 1 5A 0000",
               lat, result, cf, zf, nf, vf);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] seq;
    int ndone;
    @(negedge clk);
    start = 1'b1; op = 3'b101; a = 8'hF0; b = 8'h0F; shamt = 3'd0; flags_we = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      seq[i] = done;
    end
    start = 1'b0;
    n_total++;
    if (seq !== 8'hAA) $display("FAIL b2b_done_pattern got %b required 10101010", seq);
    else n_pass++;
    n_total++;
    if (result !== 8'hFF) $display("FAIL b2b_or_result got %h required FF", result);
    else n_pass++;
    repeat (3) @(posedge clk);
    @(negedge clk);
    start = 1'b1; op = 3'b111; a = 8'hFF; b = 8'h00; shamt = 3'd7; flags_we = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      if (i == 2) begin
        start = 1'b1; op = 3'b000; a = 8'h11; b = 8'h22; shamt = 3'd0;
      end
      if (i == 3) start = 1'b0;
      @(posedge clk); #1;
      if (done) ndone++;
    end
    n_total++;
    if (ndone != 1) $display("FAIL busy_start_ignored got %0d dones required 1", ndone);
    else n_pass++;
    n_total++;
    if ({result, cf, zf, nf, vf} !== {8'h01, 4'b1000})
      $display("FAIL shr7_ff got res=%h CZNV=%b%b%b%b required 01 1000", result, cf, zf, nf, vf);
    else n_pass++;
  endtask

  initial begin
    start = 1'b0; op = 3'd0; a = 8'h00; b = 8'h00; shamt = 3'd0; flags_we = 1'b0;
    rst_n = 1'b0;
    test_reset();
    test_add_sub();
    test_carry_chain();
    test_shift();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
